// File: rtl/bit6alu_result_collector_if.sv
// ---------------------------------------------------------------------------
// bit6alu_result_collector_if
// Purpose : bundles the ALU capture bus and the record read port of the
//           6-bit ALU result collector.
// Signals :
//   cap_valid        ALU outputs valid this cycle
//   r1_in, r2_in     ALU register outputs (W bits)
//   mux1_in          ALU mux1 output (W bits)
//   mux2_in          ALU mux2 output
//   sum_in, cout_in  full-adder sum / carry out
//   sel_in           {Opt[1:0],Opt2,C[1:0]} for this sample
//   rd_valid         record available
//   rd_ready         consumer accepts rd_data
//   rd_data          packed record {sel,cout,sum,mux2,mux1,r2,r1}
// Modports: master = stimulus/consumer side, slave = collector side.
// ---------------------------------------------------------------------------
interface bit6alu_result_collector_if #(
   parameter int W = 6
);
   localparam int RW = 3 * W + 8;

   logic          cap_valid;
   logic [W-1:0]  r1_in;
   logic [W-1:0]  r2_in;
   logic [W-1:0]  mux1_in;
   logic          mux2_in;
   logic          sum_in;
   logic          cout_in;
   logic [4:0]    sel_in;
   logic          rd_valid;
   logic          rd_ready;
   logic [RW-1:0] rd_data;

   modport master (
      output cap_valid, r1_in, r2_in, mux1_in, mux2_in, sum_in, cout_in, sel_in,
      output rd_ready,
      input  rd_valid, rd_data
   );

   modport slave (
      input  cap_valid, r1_in, r2_in, mux1_in, mux2_in, sum_in, cout_in, sel_in,
      input  rd_ready,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/bit6alu_result_collector.sv
// ---------------------------------------------------------------------------
// bit6alu_result_collector
// Purpose : samples the 6-bit ALU result outputs on a capture strobe, packs
//           each sample with its operation select into a record and buffers
//           it in a first-word-fall-through FIFO drained over valid/ready.
//           An IDLE/RUN/DONE FSM bounds each capture run to len_in samples.
// Optional: define BIT6ALU_COLLECT_SIG_EN to build a MISR signature over all
//           written records; otherwise sig_out is tied to 0.
// Ports   :
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   arm       pulse: start/restart a run of len_in samples (0 = unbounded)
//   len_in    samples per run
//   clear     synchronous flush of FIFO, counters, FSM and overflow
//   bus       capture bus + read port (slave modport)
//   count     records stored
//   full      count == DEPTH
//   overflow  sticky: a sample was dropped because the FIFO was full
//   busy      FSM in RUN
//   done      FSM in DONE
//   sig_out   result signature
// ---------------------------------------------------------------------------
module bit6alu_result_collector #(
   parameter int W     = 6,
   parameter int DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           arm,
   input  logic [7:0]                     len_in,
   input  logic                           clear,
   bit6alu_result_collector_if.slave      bus,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           full,
   output logic                           overflow,
   output logic                           busy,
   output logic                           done,
   output logic [3*W+7:0]                 sig_out
);
   localparam int RW = 3 * W + 8;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [7:0]    remain;
   logic [RW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [RW-1:0] record;
   logic          sample;
   logic          rd_fire;
   logic          wr_fire;
   logic          drop;

   assign record = {bus.sel_in, bus.cout_in, bus.sum_in, bus.mux2_in,
                    bus.mux1_in, bus.r2_in, bus.r1_in};

   assign bus.rd_valid = (count != '0);
   assign bus.rd_data  = mem[rd_ptr];
   assign full         = (count == CW'(DEPTH));

   // clear and arm take precedence over the capture/read traffic of that cycle
   assign sample  = (state == RUN) && bus.cap_valid && !arm && !clear;
   assign rd_fire = bus.rd_valid && bus.rd_ready && !clear;
   // a full FIFO still accepts a write when a slot is freed on the same edge
   assign wr_fire = sample && (!full || rd_fire);
   assign drop    = sample && full && !rd_fire;

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         // storage is zeroed so rd_data is defined before the first write
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_fire) begin
            mem[wr_ptr] <= record;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_fire && !rd_fire) begin
            count <= count + 1'b1;
         end else if (rd_fire && !wr_fire) begin
            count <= count - 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Run-control FSM. remain==0 while in RUN can only mean an unbounded run,
   // because a bounded run leaves RUN on the sample that takes it from 1 to 0.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state  <= IDLE;
         remain <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (arm) begin
         state  <= RUN;
         remain <= len_in;
         busy   <= 1'b1;
         done   <= 1'b0;
      end else if (sample) begin
         if (remain == 8'd1) begin
            state  <= DONE;
            remain <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
         end else if (remain != '0) begin
            remain <= remain - 8'd1;
         end
      end
   end

`ifdef BIT6ALU_COLLECT_SIG_EN
   logic [RW-1:0] sig;
   logic          fb;

   assign fb = sig[RW-1] ^ sig[5] ^ sig[1] ^ sig[0];

   always_ff @(posedge clk) begin
      if (reset || clear || arm) begin
         sig <= '0;
      end else if (wr_fire) begin
         sig <= {sig[RW-2:0], fb} ^ record;
      end
   end

   assign sig_out = sig;
`else
   assign sig_out = '0;
`endif

endmodule

// File: tb/tb_bit6alu_result_collector.sv
module tb_bit6alu_result_collector;
   localparam int W     = 6;
   localparam int DEPTH = 8;
   localparam int RW    = 3 * W + 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          arm;
   logic [7:0]    len_in;
   logic          clear;
   logic [3:0]    count;
   logic          full;
   logic          overflow;
   logic          busy;
   logic          done;
   logic [RW-1:0] sig_out;

   int total = 0;
   int bad   = 0;

   bit6alu_result_collector_if #(.W(W)) bus ();

   bit6alu_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .arm      (arm),
      .len_in   (len_in),
      .clear    (clear),
      .bus      (bus.slave),
      .count    (count),
      .full     (full),
      .overflow (overflow),
      .busy     (busy),
      .done     (done),
      .sig_out  (sig_out)
   );

   always #5 clk = ~clk;

   // reference model: queue of records plus run bookkeeping
   logic [RW-1:0] q[$];
   int            mode;      // 0 idle, 1 run, 2 done
   int            rem;       // samples left, 0 in run = unbounded
   bit            ovf;
   logic [RW-1:0] sig;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] cur_rec();
      return {bus.sel_in, bus.cout_in, bus.sum_in, bus.mux2_in,
              bus.mux1_in, bus.r2_in, bus.r1_in};
   endfunction

   task automatic idle_inputs();
      arm           = 1'b0;
      clear         = 1'b0;
      len_in        = 8'd0;
      bus.cap_valid = 1'b0;
      bus.rd_ready  = 1'b0;
      bus.r1_in     = '0;
      bus.r2_in     = '0;
      bus.mux1_in   = '0;
      bus.mux2_in   = 1'b0;
      bus.sum_in    = 1'b0;
      bus.cout_in   = 1'b0;
      bus.sel_in    = '0;
   endtask

   // advance one clock, update the model from the inputs presented, check outputs
   task automatic cycle();
      logic [RW-1:0] rec;
      bit            rd;
      logic          fb;
      rec = cur_rec();
      if (reset || clear) begin
         q.delete();
         mode = 0;
         rem  = 0;
         ovf  = 1'b0;
         sig  = '0;
      end else begin
         rd = (q.size() > 0) && bus.rd_ready;
         if (rd) void'(q.pop_front());
         if (arm) begin
            mode = 1;
            rem  = len_in;
            sig  = '0;
         end else if (mode == 1 && bus.cap_valid) begin
            if (q.size() < DEPTH) begin
               q.push_back(rec);
               fb  = sig[25] ^ sig[5] ^ sig[1] ^ sig[0];
               sig = {sig[24:0], fb} ^ rec;
            end else begin
               ovf = 1'b1;
            end
            if (rem == 1) begin
               mode = 2;
               rem  = 0;
            end else if (rem > 1) begin
               rem--;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("count", 64'(count), 64'(q.size()));
      chk("rd_valid", 64'(bus.rd_valid), 64'(q.size() > 0));
      chk("full", 64'(full), 64'(q.size() == DEPTH));
      chk("overflow", 64'(overflow), 64'(ovf));
      chk("busy", 64'(busy), 64'(mode == 1));
      chk("done", 64'(done), 64'(mode == 2));
      if (q.size() > 0) chk("rd_data", 64'(bus.rd_data), 64'(q[0]));
`ifdef BIT6ALU_COLLECT_SIG_EN
      chk("sig_out", 64'(sig_out), 64'(sig));
`else
      chk("sig_out", 64'(sig_out), 64'd0);
`endif
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      mode  = 0;
      rem   = 0;
      ovf   = 1'b0;
      sig   = '0;

      // reset then idle
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
      chk("t1_rd_valid", 64'(bus.rd_valid), 64'd0);
      chk("t1_count", 64'(count), 64'd0);
      chk("t1_sig", 64'(sig_out), 64'd0);
      chk("t1_done", 64'(done), 64'd0);
      chk("t1_rd_data", 64'(bus.rd_data), 64'd0);

      // bounded run of three
      arm = 1'b1; len_in = 8'd3;
      cycle();
      arm = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         bus.cap_valid = 1'b1;
         bus.r1_in     = W'(i);
         cycle();
      end
      bus.cap_valid = 1'b0;
      cycle();
      chk("t2_count", 64'(count), 64'd3);
      chk("t2_done", 64'(done), 64'd1);
      bus.rd_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         chk("t2_read", 64'(bus.rd_data[W-1:0]), 64'(i));
         cycle();
      end
      bus.rd_ready = 1'b0;
      chk("t2_empty", 64'(bus.rd_valid), 64'd0);

      // unbounded run overfilling the FIFO
      arm = 1'b1; len_in = 8'd0;
      cycle();
      arm = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.cap_valid = 1'b1;
         bus.r1_in     = W'(10 + i);
         cycle();
      end
      bus.cap_valid = 1'b0;
      chk("t3_full", 64'(full), 64'd1);
      chk("t3_count", 64'(count), 64'd8);
      chk("t3_overflow", 64'(overflow), 64'd1);
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t3_read", 64'(bus.rd_data[W-1:0]), 64'(10 + i));
         cycle();
      end
      bus.rd_ready = 1'b0;
      chk("t3_drained", 64'(bus.rd_valid), 64'd0);

      // full FIFO with concurrent write and read across pointer wrap
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      arm = 1'b1; len_in = 8'd0;
      cycle();
      arm = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.cap_valid = 1'b1;
         bus.r1_in     = W'(20 + i);
         cycle();
      end
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.r1_in = W'(40 + i);
         chk("t4_head", 64'(bus.rd_data[W-1:0]), 64'(20 + i));
         cycle();
         chk("t4_count", 64'(count), 64'd8);
      end
      bus.cap_valid = 1'b0;
      chk("t4_overflow", 64'(overflow), 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk("t4_order", 64'(bus.rd_data[W-1:0]), 64'(i < 4 ? 24 + i : 36 + i));
         cycle();
      end
      bus.rd_ready = 1'b0;

      // clear in the middle of a run with an in-flight sample
      arm = 1'b1; len_in = 8'd0;
      cycle();
      arm = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.cap_valid = 1'b1;
         bus.r1_in     = W'(50 + i);
         cycle();
      end
      chk("t5_pre_count", 64'(count), 64'd5);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      bus.cap_valid = 1'b0;
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_rd_valid", 64'(bus.rd_valid), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_overflow", 64'(overflow), 64'd0);

      // signature of a single known record
      idle_inputs();
      arm = 1'b1; len_in = 8'd1;
      cycle();
      arm = 1'b0;
      bus.cap_valid = 1'b1;
      bus.sel_in    = 5'b10110;
      bus.r1_in     = 6'h3F;
      cycle();
      bus.cap_valid = 1'b0;
`ifdef BIT6ALU_COLLECT_SIG_EN
      chk("t6_sig", 64'(sig_out), 64'h2C0003F);
`else
      chk("t6_sig", 64'(sig_out), 64'd0);
`endif
      chk("t6_done", 64'(done), 64'd1);

      // randomized traffic
      idle_inputs();
      for (int n = 0; n < 600; n++) begin
         idle_inputs();
         if ($urandom_range(0, 31) == 0) begin
            clear = 1'b1;
         end else if ($urandom_range(0, 15) == 0) begin
            arm    = 1'b1;
            len_in = 8'($urandom_range(0, 12));
         end
         if (!arm) begin
            bus.cap_valid = 1'($urandom_range(0, 1));
            bus.rd_ready  = ($urandom_range(0, 2) == 0);
         end
         bus.r1_in   = W'($urandom);
         bus.r2_in   = W'($urandom);
         bus.mux1_in = W'($urandom);
         bus.mux2_in = 1'($urandom);
         bus.sum_in  = 1'($urandom);
         bus.cout_in = 1'($urandom);
         bus.sel_in  = 5'($urandom);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
